// File: rtl/morse_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | morse_pkg : symbol codes shared with morseFSM, key decoder states     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package morse_pkg;

  localparam logic [1:0] SYM_IDLE = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_SEND = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2,
    ST_FLUSH = 2'd3
  } dec_state_e;

endpackage : morse_pkg
`default_nettype wire

// File: rtl/key_debouncer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_debouncer : 2-flop synchroniser, stability counter, edge pulses   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module key_debouncer #(
  parameter int CNT_W           = 20,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic key_db,
  output logic rise,
  output logic fall
);

  logic             sync1_q;
  logic             sync2_q;
  logic             key_db_q;
  logic             key_db_d;
  logic             key_db_dly_q;
  logic [CNT_W-1:0] db_cnt_q;
  logic [CNT_W-1:0] db_cnt_d;

  // The counter only runs while the synced level disagrees with the accepted one.
  always_comb begin
    db_cnt_d = '0;
    key_db_d = key_db_q;
    if (sync2_q != key_db_q) begin
      if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        key_db_d = ~key_db_q;
      end else begin
        db_cnt_d = db_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      key_db_q     <= 1'b0;
      key_db_dly_q <= 1'b0;
      db_cnt_q     <= '0;
    end else begin
      sync1_q      <= key;
      sync2_q      <= sync1_q;
      key_db_q     <= key_db_d;
      key_db_dly_q <= key_db_q;
      db_cnt_q     <= db_cnt_d;
    end
  end

  assign key_db = key_db_q;
  assign rise   = key_db_q & ~key_db_dly_q;
  assign fall   = ~key_db_q & key_db_dly_q;

endmodule : key_debouncer
`default_nettype wire

// File: rtl/morse_key_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | morse_key_decoder : debounced key -> DOT/DASH/SEND single-cycle pulses|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module morse_key_decoder #(
  parameter int CNT_W           = 20,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DASH_CYCLES     = 64,
  parameter int SEND_GAP_CYCLES = 128,
  parameter int MAX_SYMBOLS     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key,
  output logic [1:0] symbol,
  output logic       key_db,
  output logic       busy,
  output logic [2:0] sym_count
);

  import morse_pkg::*;

  logic             rise;
  logic             fall;
  dec_state_e       state_q;
  logic [CNT_W-1:0] press_cnt_q;
  logic [CNT_W-1:0] gap_cnt_q;
  logic [2:0]       sym_count_q;
  logic [2:0]       sym_count_inc;
  logic [1:0]       symbol_q;
  logic             busy_q;

  key_debouncer #(
    .CNT_W          (CNT_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk   (clk),
    .reset (reset),
    .key   (key),
    .key_db(key_db),
    .rise  (rise),
    .fall  (fall)
  );

  assign sym_count_inc = sym_count_q + 3'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      press_cnt_q <= '0;
      gap_cnt_q   <= '0;
      sym_count_q <= '0;
      symbol_q    <= SYM_IDLE;
      busy_q      <= 1'b0;
    end else begin
      symbol_q <= SYM_IDLE;
      case (state_q)
        // Only a fresh rise starts a press; a level still held after FLUSH is ignored.
        ST_IDLE: begin
          if (rise) begin
            state_q     <= ST_PRESS;
            press_cnt_q <= CNT_W'(1);
            busy_q      <= 1'b1;
          end
        end
        ST_PRESS: begin
          if (press_cnt_q != '1) begin
            press_cnt_q <= press_cnt_q + CNT_W'(1);
          end
          if (fall) begin
            symbol_q    <= (press_cnt_q >= CNT_W'(DASH_CYCLES)) ? SYM_DASH : SYM_DOT;
            sym_count_q <= sym_count_inc;
            if (sym_count_inc == 3'(MAX_SYMBOLS)) begin
              state_q <= ST_FLUSH;
            end else begin
              state_q   <= ST_GAP;
              gap_cnt_q <= CNT_W'(1);
            end
          end
        end
        ST_GAP: begin
          gap_cnt_q <= gap_cnt_q + CNT_W'(1);
          if (gap_cnt_q == CNT_W'(SEND_GAP_CYCLES)) begin
            symbol_q    <= SYM_SEND;
            sym_count_q <= '0;
            // A press landing on the timeout cycle opens the next letter.
            if (rise) begin
              state_q     <= ST_PRESS;
              press_cnt_q <= CNT_W'(1);
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else if (rise) begin
            state_q     <= ST_PRESS;
            press_cnt_q <= CNT_W'(1);
          end
        end
        ST_FLUSH: begin
          symbol_q    <= SYM_SEND;
          sym_count_q <= '0;
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign symbol    = symbol_q;
  assign busy      = busy_q;
  assign sym_count = sym_count_q;

endmodule : morse_key_decoder
`default_nettype wire

// File: tb/tb_morse_key_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_morse_key_decoder : directed scenarios with hand-computed timing   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_morse_key_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key = 1'b0;
  logic [1:0] symbol;
  logic       key_db;
  logic       busy;
  logic [2:0] sym_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic db_seen = 1'b0;

  typedef struct {
    int         cyc;
    logic [1:0] sym;
    logic [2:0] cnt;
  } ev_t;
  ev_t evq[$];

  morse_key_decoder #(
    .CNT_W          (20),
    .DEBOUNCE_CYCLES(4),
    .DASH_CYCLES    (20),
    .SEND_GAP_CYCLES(40),
    .MAX_SYMBOLS    (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key      (key),
    .symbol   (symbol),
    .key_db   (key_db),
    .busy     (busy),
    .sym_count(sym_count)
  );

  always #5 clk = ~clk;

  // Log every non-idle symbol with the index of the posedge that produced it.
  always begin
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    if (symbol !== 2'b00) evq.push_back('{cyc, symbol, sym_count});
    if (key_db === 1'b1) db_seen = 1'b1;
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    key   = 1'b0;
    hold(3);
    checks++; if (symbol !== 2'b00) begin errors++; $display("FAIL reset_symbol: got %b expected 00", symbol); end
    checks++; if (key_db !== 1'b0) begin errors++; $display("FAIL reset_key_db: got %b expected 0", key_db); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (sym_count !== 3'd0) begin errors++; $display("FAIL reset_sym_count: got %0d expected 0", sym_count); end
    reset = 1'b0;
    hold(5);
  endtask

  task automatic test_single_dot();
    int t0;
    evq.delete();
    key = 1'b1; t0 = cyc;
    hold(10);
    key = 1'b0;
    hold(20);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dot_busy_gap: got %b expected 1", busy); end
    hold(40);
    checks++;
    if (evq.size() != 2) begin
      errors++; $display("FAIL dot_event_count: got %0d expected 2", evq.size());
    end else begin
      checks++; if (evq[0].sym !== 2'b01 || evq[0].cyc != t0 + 17) begin
        errors++; $display("FAIL dot_symbol: got %b at %0d expected 01 at %0d", evq[0].sym, evq[0].cyc, t0 + 17); end
      checks++; if (evq[1].sym !== 2'b11 || evq[1].cyc != t0 + 57) begin
        errors++; $display("FAIL dot_send: got %b at %0d expected 11 at %0d", evq[1].sym, evq[1].cyc, t0 + 57); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dot_busy_end: got %b expected 0", busy); end
    checks++; if (sym_count !== 3'd0) begin errors++; $display("FAIL dot_count_end: got %0d expected 0", sym_count); end
  endtask

  task automatic test_letter_n();
    int t0;
    evq.delete();
    key = 1'b1; t0 = cyc;
    hold(30);
    key = 1'b0;
    hold(10);
    key = 1'b1;
    hold(8);
    key = 1'b0;
    hold(60);
    checks++;
    if (evq.size() != 3) begin
      errors++; $display("FAIL n_event_count: got %0d expected 3", evq.size());
    end else begin
      checks++; if (evq[0].sym !== 2'b10 || evq[0].cyc != t0 + 37) begin
        errors++; $display("FAIL n_dash: got %b at %0d expected 10 at %0d", evq[0].sym, evq[0].cyc, t0 + 37); end
      checks++; if (evq[1].sym !== 2'b01 || evq[1].cyc != t0 + 55) begin
        errors++; $display("FAIL n_dot: got %b at %0d expected 01 at %0d", evq[1].sym, evq[1].cyc, t0 + 55); end
      checks++; if (evq[1].cnt !== 3'd2) begin
        errors++; $display("FAIL n_count: got %0d expected 2", evq[1].cnt); end
      checks++; if (evq[2].sym !== 2'b11 || evq[2].cyc != t0 + 95) begin
        errors++; $display("FAIL n_send: got %b at %0d expected 11 at %0d", evq[2].sym, evq[2].cyc, t0 + 95); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL n_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_glitch();
    evq.delete();
    db_seen = 1'b0;
    key = 1'b1; hold(2);
    key = 1'b0; hold(3);
    key = 1'b1; hold(1);
    key = 1'b0; hold(1);
    key = 1'b1; hold(1);
    key = 1'b0; hold(20);
    checks++; if (db_seen !== 1'b0) begin errors++; $display("FAIL glitch_key_db: got 1 expected 0"); end
    checks++; if (evq.size() != 0) begin errors++; $display("FAIL glitch_symbols: got %0d expected 0", evq.size()); end
  endtask

  task automatic test_letter_h();
    int t0;
    evq.delete();
    t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      key = 1'b1; hold(8);
      key = 1'b0; hold(10);
    end
    hold(20);
    checks++;
    if (evq.size() != 5) begin
      errors++; $display("FAIL h_event_count: got %0d expected 5", evq.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (evq[k].sym !== 2'b01 || evq[k].cyc != t0 + 18 * k + 15 || evq[k].cnt !== 3'(k + 1)) begin
          errors++;
          $display("FAIL h_dot%0d: got %b at %0d cnt %0d expected 01 at %0d cnt %0d",
                   k, evq[k].sym, evq[k].cyc, evq[k].cnt, t0 + 18 * k + 15, k + 1);
        end
      end
      checks++; if (evq[4].sym !== 2'b11 || evq[4].cyc != t0 + 70 || evq[4].cnt !== 3'd0) begin
        errors++; $display("FAIL h_send: got %b at %0d cnt %0d expected 11 at %0d cnt 0",
                           evq[4].sym, evq[4].cyc, evq[4].cnt, t0 + 70); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL h_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_press();
    int   tr;
    logic bad;
    evq.delete();
    key = 1'b1;
    hold(15);
    reset = 1'b1;
    bad = 1'b0;
    repeat (3) begin
      hold(1);
      if (symbol !== 2'b00 || sym_count !== 3'd0 || busy !== 1'b0 || key_db !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL midreset_outputs: got nonzero expected all zero"); end
    reset = 1'b0; tr = cyc;
    hold(10);
    key = 1'b0;
    hold(70);
    checks++;
    if (evq.size() != 2) begin
      errors++; $display("FAIL midreset_event_count: got %0d expected 2", evq.size());
    end else begin
      checks++; if (evq[0].sym !== 2'b01 || evq[0].cyc != tr + 17) begin
        errors++; $display("FAIL midreset_dot: got %b at %0d expected 01 at %0d", evq[0].sym, evq[0].cyc, tr + 17); end
      checks++; if (evq[1].sym !== 2'b11 || evq[1].cyc != tr + 57) begin
        errors++; $display("FAIL midreset_send: got %b at %0d expected 11 at %0d", evq[1].sym, evq[1].cyc, tr + 57); end
    end
  endtask

  task automatic test_reset_idle();
    logic bad_in;
    logic bad_after;
    evq.delete();
    key = 1'b0;
    reset = 1'b1;
    bad_in = 1'b0;
    repeat (4) begin
      hold(1);
      if (symbol !== 2'b00 || sym_count !== 3'd0 || busy !== 1'b0 || key_db !== 1'b0) bad_in = 1'b1;
    end
    checks++; if (bad_in !== 1'b0) begin errors++; $display("FAIL idlereset_during: got nonzero expected all zero"); end
    reset = 1'b0;
    bad_after = 1'b0;
    repeat (10) begin
      hold(1);
      if (symbol !== 2'b00 || sym_count !== 3'd0 || busy !== 1'b0 || key_db !== 1'b0) bad_after = 1'b1;
    end
    checks++; if (bad_after !== 1'b0) begin errors++; $display("FAIL idlereset_after: got nonzero expected all zero"); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_dot();
    test_letter_n();
    test_glitch();
    test_letter_h();
    test_reset_mid_press();
    test_reset_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_morse_key_decoder
`default_nettype wire
